// File: rtl/bj_game_ctrl_if.sv
// Button, card-handshake and display bundle of the blackjack round controller.
// slave = controller side, master = stimulus / button decoder / card generator side.
interface bj_game_ctrl_if;
  logic       start;
  logic       player1;
  logic       player2;
  logic       deal;
  logic       hit;
  logic       stand;
  // card_req rises from a register and stays high until the cycle card_valid is seen;
  // the card is taken on that edge and card_req falls the next cycle.
  logic       card_req;
  logic       card_valid;
  logic [3:0] card_value;
  logic [2:0] state_code;
  logic       player_sel;
  logic [4:0] player_score;
  logic [4:0] dealer_score;
  logic [2:0] player_cards;
  logic [2:0] dealer_cards;
  logic [1:0] result;

  modport slave (
    input  start, player1, player2, deal, hit, stand, card_valid, card_value,
    output card_req, state_code, player_sel, player_score, dealer_score,
           player_cards, dealer_cards, result
  );

  modport master (
    output start, player1, player2, deal, hit, stand, card_valid, card_value,
    input  card_req, state_code, player_sel, player_score, dealer_score,
           player_cards, dealer_cards, result
  );
endinterface

// File: rtl/bj_game_ctrl.sv
// Blackjack round controller: button edge detection, round FSM, card fetch handshake, scoring.
// Define DEALER_HITS_SOFT17_EN to make the dealer draw on soft 17.
module bj_game_ctrl #(
  parameter int unsigned DEALER_STAND = 17,
  parameter int unsigned MAX_CARDS    = 7
) (
  input  logic         clk,
  input  logic         rst,
  bj_game_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_MENU      = 3'd0,
    S_SELECT    = 3'd1,
    S_WAIT_DEAL = 3'd2,
    S_INIT_DEAL = 3'd3,
    S_PLAYER    = 3'd4,
    S_DEALER    = 3'd5,
    S_RESULT    = 3'd6
  } state_t;

  localparam logic [4:0] STAND_L = 5'(DEALER_STAND);
  localparam logic [2:0] MAX_L   = 3'(MAX_CARDS);

  state_t     state_q, state_d;
  logic [5:0] btn_q;
  logic       req_q, req_d;
  logic       dest_q, dest_d;
  logic [2:0] cnt_q, cnt_d;
  logic       sel_q, sel_d;
  logic [1:0] result_q, result_d;
  logic [4:0] p_hard_q, d_hard_q;
  logic       p_ace_q, d_ace_q;
  logic [2:0] p_cards_q, d_cards_q;
  logic       clear;

  function automatic logic [4:0] best_score(input logic [4:0] hard, input logic ace);
    return (ace && hard <= 5'd11) ? hard + 5'd10 : hard;
  endfunction

  logic [5:0] levels, ev;
  logic [4:0] p_best, d_best, card_v;
  logic       accept, d_draw;
  logic [1:0] decide;

  assign levels = {bus.start, bus.player1, bus.player2, bus.deal, bus.hit, bus.stand};
  // Presses that land while a card is outstanding are dropped rather than queued.
  assign ev     = levels & ~btn_q & {6{~req_q}};
  assign accept = req_q & bus.card_valid;
  assign card_v = (bus.card_value == 4'd0 || bus.card_value > 4'd10) ? 5'd10 : {1'b0, bus.card_value};
  assign p_best = best_score(p_hard_q, p_ace_q);
  assign d_best = best_score(d_hard_q, d_ace_q);

`ifdef DEALER_HITS_SOFT17_EN
  assign d_draw = (d_best < STAND_L) || (d_ace_q && d_hard_q == 5'd7);
`else
  assign d_draw = (d_best < STAND_L);
`endif

  always_comb begin
    if (p_best > 5'd21)       decide = 2'd2;
    else if (d_best > 5'd21)  decide = 2'd1;
    else if (p_best > d_best) decide = 2'd1;
    else if (p_best < d_best) decide = 2'd2;
    else                      decide = 2'd3;
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    dest_d   = dest_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    result_d = result_q;
    clear    = 1'b0;
    if (accept) req_d = 1'b0;
    case (state_q)
      S_MENU:   if (ev[5]) state_d = S_SELECT;
      S_SELECT: begin
        if (ev[4]) begin
          sel_d   = 1'b0;
          state_d = S_WAIT_DEAL;
        end else if (ev[3]) begin
          sel_d   = 1'b1;
          state_d = S_WAIT_DEAL;
        end
      end
      S_WAIT_DEAL: if (ev[2]) begin
        clear   = 1'b1;
        state_d = S_INIT_DEAL;
      end
      S_INIT_DEAL: begin
        // Four fetches alternating player/dealer, selected by the low count bit.
        if (!req_q) begin
          if (cnt_q == 3'd4) state_d = S_PLAYER;
          else begin
            req_d  = 1'b1;
            dest_d = cnt_q[0];
          end
        end else if (accept) begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_PLAYER: if (!req_q) begin
        if (p_best == 5'd21) state_d = S_DEALER;
        else if (p_best > 5'd21) begin
          state_d  = S_RESULT;
          result_d = decide;
        end else if (ev[1] && p_cards_q < MAX_L) begin
          req_d  = 1'b1;
          dest_d = 1'b0;
        end else if (ev[0]) state_d = S_DEALER;
      end
      S_DEALER: if (!req_q) begin
        if (d_draw && d_cards_q < MAX_L) begin
          req_d  = 1'b1;
          dest_d = 1'b1;
        end else begin
          state_d  = S_RESULT;
          result_d = decide;
        end
      end
      S_RESULT: begin
        if (ev[5]) begin
          state_d  = S_MENU;
          result_d = 2'd0;
        end else if (ev[2]) begin
          clear   = 1'b1;
          state_d = S_INIT_DEAL;
        end
      end
      default: state_d = S_MENU;
    endcase
    if (clear) begin
      cnt_d    = 3'd0;
      result_d = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_MENU;
      btn_q    <= 6'd0;
      req_q    <= 1'b0;
      dest_q   <= 1'b0;
      cnt_q    <= 3'd0;
      sel_q    <= 1'b0;
      result_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      btn_q    <= levels;
      req_q    <= req_d;
      dest_q   <= dest_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      p_hard_q  <= 5'd0;
      p_ace_q   <= 1'b0;
      p_cards_q <= 3'd0;
      d_hard_q  <= 5'd0;
      d_ace_q   <= 1'b0;
      d_cards_q <= 3'd0;
    end else if (accept) begin
      if (!dest_q) begin
        p_hard_q  <= p_hard_q + card_v;
        p_ace_q   <= p_ace_q | (card_v == 5'd1);
        p_cards_q <= (p_cards_q == MAX_L) ? p_cards_q : p_cards_q + 3'd1;
      end else begin
        d_hard_q  <= d_hard_q + card_v;
        d_ace_q   <= d_ace_q | (card_v == 5'd1);
        d_cards_q <= (d_cards_q == MAX_L) ? d_cards_q : d_cards_q + 3'd1;
      end
    end
  end

  assign bus.card_req     = req_q;
  assign bus.state_code   = state_q;
  assign bus.player_sel   = sel_q;
  assign bus.player_score = p_best;
  assign bus.dealer_score = d_best;
  assign bus.player_cards = p_cards_q;
  assign bus.dealer_cards = d_cards_q;
  assign bus.result       = result_q;
endmodule

// File: tb/tb_bj_game_ctrl.sv
// Directed bench for bj_game_ctrl: round scenarios with hand-computed scores plus a state-sequence scoreboard.
module tb_bj_game_ctrl;
  localparam logic [5:0] B_START = 6'b100000;
  localparam logic [5:0] B_P1    = 6'b010000;
  localparam logic [5:0] B_P2    = 6'b001000;
  localparam logic [5:0] B_DEAL  = 6'b000100;
  localparam logic [5:0] B_HIT   = 6'b000010;
  localparam logic [5:0] B_STAND = 6'b000001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bj_game_ctrl_if bus ();

  bj_game_ctrl #(.DEALER_STAND(17), .MAX_CARDS(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [2:0] exp_q[$];
  logic [2:0] last_state = 3'd0;
  logic       mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Every state change must match the next expected state.
  always @(negedge clk) begin
    if (mon_en && bus.state_code != last_state) begin
      if (exp_q.size() == 0) check("state_seq_extra", bus.state_code, 3'd7);
      else                   check("state_seq", bus.state_code, exp_q.pop_front());
      last_state = bus.state_code;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [5:0] m);
    {bus.start, bus.player1, bus.player2, bus.deal, bus.hit, bus.stand} = m;
    @(negedge clk);
    {bus.start, bus.player1, bus.player2, bus.deal, bus.hit, bus.stand} = 6'd0;
  endtask

  task automatic serve_card(input logic [3:0] v);
    int n = 0;
    while (!bus.card_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.card_req) check("card_req_timeout", bus.card_req, 1);
    else begin
      bus.card_valid = 1'b1;
      bus.card_value = v;
      @(negedge clk);
      bus.card_valid = 1'b0;
      bus.card_value = 4'd0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    {bus.start, bus.player1, bus.player2, bus.deal, bus.hit, bus.stand} = 6'd0;
    bus.card_valid = 1'b0;
    bus.card_value = 4'd0;
    rst = 1'b1;
    @(negedge clk);
    idle(3);
    rst = 1'b0;
    check("rst_state", bus.state_code, 0);
    check("rst_req", bus.card_req, 0);
    check("rst_pscore", bus.player_score, 0);
    check("rst_dscore", bus.dealer_score, 0);
    check("rst_result", bus.result, 0);
    check("rst_sel", bus.player_sel, 0);
    last_state = 3'd0;
    mon_en = 1'b1;

    // Held start gives a single MENU->SELECT step.
    exp_q.push_back(3'd1);
    bus.start = 1'b1;
    idle(5);
    bus.start = 1'b0;
    check("t1_select", bus.state_code, 1);
    exp_q.push_back(3'd2);
    press(B_P2);
    idle(1);
    check("t1_wait_deal", bus.state_code, 2);
    check("t1_sel", bus.player_sel, 1);

    // Blackjack vs dealer 16, dealer draws 5 to 21: push.
    exp_q.push_back(3'd3); exp_q.push_back(3'd4); exp_q.push_back(3'd5); exp_q.push_back(3'd6);
    press(B_DEAL);
    serve_card(4'd10); serve_card(4'd9); serve_card(4'd1); serve_card(4'd7);
    check("t2_pscore", bus.player_score, 21);
    check("t2_pcards", bus.player_cards, 2);
    check("t2_dscore", bus.dealer_score, 16);
    serve_card(4'd5);
    idle(3);
    check("t2_state", bus.state_code, 6);
    check("t2_dscore_final", bus.dealer_score, 21);
    check("t2_dcards", bus.dealer_cards, 3);
    check("t2_result", bus.result, 3);

    // Player 16 hits an 8 and busts; dealer draws nothing.
    exp_q.push_back(3'd3); exp_q.push_back(3'd4); exp_q.push_back(3'd6);
    press(B_DEAL);
    check("t3_result_clr", bus.result, 0);
    check("t3_pcards_clr", bus.player_cards, 0);
    serve_card(4'd10); serve_card(4'd10); serve_card(4'd6); serve_card(4'd7);
    idle(2);
    check("t3_player", bus.state_code, 4);
    check("t3_pscore", bus.player_score, 16);
    press(B_HIT);
    serve_card(4'd8);
    idle(3);
    check("t3_pscore_bust", bus.player_score, 24);
    check("t3_state", bus.state_code, 6);
    check("t3_result", bus.result, 2);
    check("t3_dcards", bus.dealer_cards, 2);

    // Dealer soft 17 (ace,6) against player 18.
    exp_q.push_back(3'd3); exp_q.push_back(3'd4); exp_q.push_back(3'd5); exp_q.push_back(3'd6);
    press(B_DEAL);
    serve_card(4'd10); serve_card(4'd1); serve_card(4'd8); serve_card(4'd6);
    idle(2);
    check("t4_pscore", bus.player_score, 18);
    check("t4_dscore", bus.dealer_score, 17);
    press(B_STAND);
`ifdef DEALER_HITS_SOFT17_EN
    serve_card(4'd2);
    idle(3);
    check("t4_dscore_s17", bus.dealer_score, 19);
    check("t4_result_s17", bus.result, 2);
`else
    cnt = 0;
    repeat (4) begin
      if (bus.card_req) cnt++;
      @(negedge clk);
    end
    check("t4_no_req", cnt, 0);
    check("t4_dcards", bus.dealer_cards, 2);
    check("t4_dscore_stand", bus.dealer_score, 17);
    check("t4_result", bus.result, 1);
`endif
    check("t4_state", bus.state_code, 6);

    // Card withheld: req stays up, presses dropped; then reset mid-handshake.
    exp_q.push_back(3'd3); exp_q.push_back(3'd4);
    press(B_DEAL);
    serve_card(4'd2); serve_card(4'd10); serve_card(4'd3); serve_card(4'd5);
    idle(2);
    check("t5_pscore", bus.player_score, 5);
    press(B_HIT);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.card_req) cnt++;
      bus.stand = (i == 5);
      bus.hit   = (i == 10);
      @(negedge clk);
    end
    bus.stand = 1'b0;
    bus.hit   = 1'b0;
    check("t5_req_held", cnt, 20);
    check("t5_state", bus.state_code, 4);
    check("t5_pcards", bus.player_cards, 2);
    exp_q.push_back(3'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_req", bus.card_req, 0);
    check("t5_rst_state", bus.state_code, 0);
    check("t5_rst_pscore", bus.player_score, 0);

    // Hit beats stand in one cycle; hits saturate at seven cards.
    exp_q.push_back(3'd1); exp_q.push_back(3'd2); exp_q.push_back(3'd3); exp_q.push_back(3'd4);
    press(B_START);
    press(B_P1);
    idle(1);
    check("t6_sel", bus.player_sel, 0);
    press(B_DEAL);
    serve_card(4'd1); serve_card(4'd10); serve_card(4'd1); serve_card(4'd9);
    idle(2);
    check("t6_pscore", bus.player_score, 12);
    press(B_HIT | B_STAND);
    serve_card(4'd1);
    idle(3);
    check("t6_one_fetch", bus.card_req, 0);
    check("t6_state", bus.state_code, 4);
    check("t6_pcards3", bus.player_cards, 3);
    check("t6_pscore13", bus.player_score, 13);
    for (int i = 0; i < 4; i++) begin
      press(B_HIT);
      serve_card(4'd1);
      idle(2);
    end
    check("t6_pcards7", bus.player_cards, 7);
    check("t6_pscore17", bus.player_score, 17);
    press(B_HIT);
    cnt = 0;
    repeat (5) begin
      if (bus.card_req) cnt++;
      @(negedge clk);
    end
    check("t6_hit_at_max", cnt, 0);
    check("t6_pcards_max", bus.player_cards, 7);
    exp_q.push_back(3'd5); exp_q.push_back(3'd6);
    press(B_STAND);
    idle(3);
    check("t6_state_result", bus.state_code, 6);
    check("t6_result", bus.result, 2);
    exp_q.push_back(3'd0);
    press(B_START);
    idle(1);
    check("t6_menu", bus.state_code, 0);
    check("t6_result_clr", bus.result, 0);

    idle(2);
    check("state_seq_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
